// File: rtl/rggen_rtl_pkg.sv
// Shared bus types: access kinds and response status codes.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_WRITE        = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_POSTED_WRITE = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY        = 2'b00,
        RGGEN_EXOKAY      = 2'b01,
        RGGEN_SLAVE_ERROR = 2'b10,
        RGGEN_ERROR       = 2'b11
    } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// Register bus interface: one request/ready handshake with captured status and read data.
interface rggen_bus_if
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                     valid;
    rggen_access              access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic                     ready;
    rggen_status              status;
    logic [BUS_WIDTH-1:0]     read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

// File: rtl/rggen_initiator_fifo.sv
// Command queue: circular buffer with an occupancy counter to tell full from empty.
module rggen_initiator_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [COUNT_WIDTH-1:0] count;
    logic                   push_en;
    logic                   pop_en;

    assign o_full     = (count == COUNT_WIDTH'(DEPTH));
    assign o_empty    = (count == '0);
    assign push_en    = i_push && !o_full;
    assign pop_en     = i_pop && !o_empty;
    assign o_pop_data = mem[rd_ptr];

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= (wr_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr + PTR_WIDTH'(1);
            end
            if (pop_en) begin
                rd_ptr <= (rd_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + PTR_WIDTH'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + COUNT_WIDTH'(1);
                2'b01:   count <= count - COUNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care while the queue is empty.
    always_ff @(posedge i_clk) begin
        if (push_en) begin
            mem[wr_ptr] <= i_push_data;
        end
    end
endmodule

// File: rtl/rggen_bus_initiator.sv
// Queued bus initiator: buffers commands and runs them one at a time on the register bus.
module rggen_bus_initiator
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int COMMAND_DEPTH = 4
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  rggen_access              i_cmd_access,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
    input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output rggen_status              o_rsp_status,
    output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
    output logic                     o_busy,
    rggen_bus_if.master              bus_if
);
    localparam int STROBE_WIDTH = BUS_WIDTH / 8;
    localparam int ACCESS_WIDTH = $bits(rggen_access);
    localparam int CMD_WIDTH    = ACCESS_WIDTH + ADDRESS_WIDTH + BUS_WIDTH + STROBE_WIDTH;
    localparam int DATA_LSB     = STROBE_WIDTH;
    localparam int ADDR_LSB     = STROBE_WIDTH + BUS_WIDTH;
    localparam int ACCESS_LSB   = ADDR_LSB + ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RESPONSE
    } state_e;

    state_e                   state_q;
    state_e                   state_d;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CMD_WIDTH-1:0]     push_data;
    logic [CMD_WIDTH-1:0]     head;

    rggen_access              req_access_q;
    logic [ADDRESS_WIDTH-1:0] req_address_q;
    logic [BUS_WIDTH-1:0]     req_write_data_q;
    logic [STROBE_WIDTH-1:0]  req_strobe_q;
    rggen_status              rsp_status_q;
    logic [BUS_WIDTH-1:0]     rsp_read_data_q;

    assign push_data = {i_cmd_access, i_cmd_address, i_cmd_write_data, i_cmd_strobe};

    rggen_initiator_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (COMMAND_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (i_cmd_valid),
        .i_push_data (push_data),
        .i_pop       (pop),
        .o_pop_data  (head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    // Readiness depends only on occupancy, never on a same-cycle pop.
    assign o_cmd_ready = !fifo_full;
    assign o_busy      = (state_q != IDLE) || !fifo_empty;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and queue pop decision.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = REQUEST;
                end
            end
            REQUEST: begin
                if (bus_if.ready) begin
                    state_d = RESPONSE;
                end
            end
            RESPONSE: begin
                if (i_rsp_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = REQUEST;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request register: loaded from the queue head on every pop, held through REQUEST.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_access_q     <= rggen_access'('0);
            req_address_q    <= '0;
            req_write_data_q <= '0;
            req_strobe_q     <= '0;
        end else if (pop) begin
            req_access_q     <= rggen_access'(head[ACCESS_LSB +: ACCESS_WIDTH]);
            req_address_q    <= head[ADDR_LSB +: ADDRESS_WIDTH];
            req_write_data_q <= head[DATA_LSB +: BUS_WIDTH];
            req_strobe_q     <= head[0 +: STROBE_WIDTH];
        end
    end

    // Response registers: captured on the bus handshake, held until the next one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_status_q    <= RGGEN_OKAY;
            rsp_read_data_q <= '0;
        end else if ((state_q == REQUEST) && bus_if.ready) begin
            rsp_status_q    <= bus_if.status;
            rsp_read_data_q <= bus_if.read_data;
        end
    end

    assign bus_if.valid      = (state_q == REQUEST);
    assign bus_if.access     = req_access_q;
    assign bus_if.address    = req_address_q;
    assign bus_if.write_data = req_write_data_q;
    assign bus_if.strobe     = req_strobe_q;

    assign o_rsp_valid     = (state_q == RESPONSE);
    assign o_rsp_status    = rsp_status_q;
    assign o_rsp_read_data = rsp_read_data_q;
endmodule

// File: tb/tb_rggen_bus_initiator.sv
// Scoreboard bench: a randomised target model, directed scenarios and a decoupled monitor.
module tb_rggen_bus_initiator;
    import rggen_rtl_pkg::*;

    localparam int AW    = 8;
    localparam int BW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        rggen_access       acc;
        logic [AW-1:0]     addr;
        logic [BW-1:0]     data;
        logic [BW/8-1:0]   strb;
    } cmd_t;

    typedef struct packed {
        rggen_status   st;
        logic [BW-1:0] data;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    rggen_access     cmd_access;
    logic [AW-1:0]   cmd_address;
    logic [BW-1:0]   cmd_write_data;
    logic [BW/8-1:0] cmd_strobe;
    logic            rsp_valid;
    logic            rsp_ready;
    rggen_status     rsp_status;
    logic [BW-1:0]   rsp_read_data;
    logic            busy;

    rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus_if ();

    rggen_bus_initiator #(
        .ADDRESS_WIDTH (AW),
        .BUS_WIDTH     (BW),
        .COMMAND_DEPTH (DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_cmd_valid      (cmd_valid),
        .o_cmd_ready      (cmd_ready),
        .i_cmd_access     (cmd_access),
        .i_cmd_address    (cmd_address),
        .i_cmd_write_data (cmd_write_data),
        .i_cmd_strobe     (cmd_strobe),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_status     (rsp_status),
        .o_rsp_read_data  (rsp_read_data),
        .o_busy           (busy),
        .bus_if           (bus_if)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    cmd_t exp_cmd_q[$];
    rsp_t exp_rsp_q[$];

    // Target knobs: negative means randomise.
    int            tgt_force_wait   = -1;
    int            tgt_force_status = -1;
    bit            tgt_force_data   = 1'b0;
    logic [BW-1:0] tgt_data_value   = '0;
    int            tgt_wait         = 0;

    bit   rsp_random    = 1'b0;
    logic rsp_ready_dir = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Target model: picks a wait count per transaction and answers after that many cycles.
    initial begin
        int left;
        bit in_txn;
        in_txn = 1'b0;
        left = 0;
        bus_if.ready     = 1'b0;
        bus_if.status    = RGGEN_OKAY;
        bus_if.read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !bus_if.valid) begin
                bus_if.ready = 1'b0;
                in_txn = 1'b0;
            end else begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    tgt_wait = (tgt_force_wait >= 0) ? tgt_force_wait : int'($urandom_range(0, 3));
                    left = tgt_wait;
                end
                if (left == 0) begin
                    bus_if.ready     = 1'b1;
                    bus_if.status    = (tgt_force_status >= 0) ? rggen_status'(tgt_force_status[1:0])
                                                               : rggen_status'($urandom_range(0, 3));
                    bus_if.read_data = tgt_force_data ? tgt_data_value : BW'($urandom);
                end else begin
                    bus_if.ready = 1'b0;
                    left--;
                end
            end
        end
    end

    // Response-consumer: either held at a directed level or randomly toggled.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = rsp_random ? ($urandom_range(0, 2) != 0) : rsp_ready_dir;
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    bit            b_in_txn = 1'b0;
    int            vcount = 0;
    logic [63:0]   b_hold = '0;
    bit            r_in = 1'b0;
    logic [63:0]   r_hold = '0;
    bit            rsp_next_chk = 1'b0;
    bit            req_next_chk = 1'b0;
    bit            req_next_exp = 1'b0;

    always @(negedge clk) begin
        cmd_t c;
        rsp_t r;
        logic [63:0] fields;
        if (!rst_n) begin
            b_in_txn = 1'b0;
            r_in = 1'b0;
            rsp_next_chk = 1'b0;
            req_next_chk = 1'b0;
        end else begin
            fields = 64'({bus_if.access, bus_if.address, bus_if.write_data, bus_if.strobe});
            if (rsp_next_chk) begin
                check("single_valid_after_ready", 64'(bus_if.valid), 64'(0));
                check("rsp_valid_after_ready", 64'(rsp_valid), 64'(1));
                rsp_next_chk = 1'b0;
            end
            if (req_next_chk) begin
                check("issue_after_rsp_accept", 64'(bus_if.valid), 64'(req_next_exp));
                req_next_chk = 1'b0;
            end
            if (bus_if.valid) begin
                if (!b_in_txn) begin
                    b_in_txn = 1'b1;
                    vcount = 0;
                    b_hold = fields;
                    if (exp_cmd_q.size() == 0) begin
                        check("unexpected_request", 64'(1), 64'(0));
                    end else begin
                        c = exp_cmd_q.pop_front();
                        check("request_fields", fields, 64'(c));
                    end
                end else begin
                    check("request_stable", fields, b_hold);
                end
                vcount++;
                if (bus_if.ready) begin
                    check("valid_cycle_count", 64'(vcount), 64'(tgt_wait + 1));
                    r.st = bus_if.status;
                    r.data = bus_if.read_data;
                    exp_rsp_q.push_back(r);
                    b_in_txn = 1'b0;
                    rsp_next_chk = 1'b1;
                end
            end
            if (rsp_valid) begin
                check("no_request_during_response", 64'(bus_if.valid), 64'(0));
                if (!r_in) begin
                    r_in = 1'b1;
                    r_hold = 64'({rsp_status, rsp_read_data});
                end else begin
                    check("response_stable", 64'({rsp_status, rsp_read_data}), r_hold);
                end
                if (rsp_ready) begin
                    r_in = 1'b0;
                    if (exp_rsp_q.size() == 0) begin
                        check("unexpected_response", 64'(1), 64'(0));
                    end else begin
                        r = exp_rsp_q.pop_front();
                        check("response_status", 64'(rsp_status), 64'(r.st));
                        check("response_data", 64'(rsp_read_data), 64'(r.data));
                    end
                    // Commands already queued at this edge must be issued the very next cycle.
                    req_next_chk = 1'b1;
                    req_next_exp = (exp_cmd_q.size() > 0);
                end
            end
            if (cmd_valid && cmd_ready) begin
                c.acc = cmd_access;
                c.addr = cmd_address;
                c.data = cmd_write_data;
                c.strb = cmd_strobe;
                exp_cmd_q.push_back(c);
            end
        end
    end

    task automatic drive_cmd(input rggen_access a, input logic [AW-1:0] ad,
                             input logic [BW-1:0] d, input logic [BW/8-1:0] s);
        cmd_valid = 1'b1;
        cmd_access = a;
        cmd_address = ad;
        cmd_write_data = d;
        cmd_strobe = s;
    endtask

    // Offer one command until accepted; starts and ends just after a rising edge.
    task automatic send_cmd(input rggen_access a, input logic [AW-1:0] ad,
                            input logic [BW-1:0] d, input logic [BW/8-1:0] s);
        int n;
        n = 0;
        drive_cmd(a, ad, d, s);
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 500);
        if (n >= 500) check("cmd_accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || rsp_valid || exp_rsp_q.size() != 0) && n < 3000);
        check("drain_timeout", 64'(n < 3000), 64'(1));
        check("drain_cmd_queue", 64'(exp_cmd_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic rggen_access rand_access();
        case ($urandom_range(0, 2))
            0:       return RGGEN_READ;
            1:       return RGGEN_WRITE;
            default: return RGGEN_POSTED_WRITE;
        endcase
    endfunction

    initial begin
        int n;
        int quiet;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_access = RGGEN_READ;
        cmd_address = '0;
        cmd_write_data = '0;
        cmd_strobe = '0;
        #1;
        check("reset_bus_valid", 64'(bus_if.valid), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        check("reset_rsp_regs", 64'({rsp_status, rsp_read_data}), 64'(0));
        check("reset_req_regs", 64'({bus_if.address, bus_if.write_data, bus_if.strobe}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read with three wait states; first valid two cycles after acceptance.
        tgt_force_wait = 3;
        tgt_force_status = int'(RGGEN_OKAY);
        tgt_force_data = 1'b1;
        tgt_data_value = 32'hCAFE_F00D;
        drive_cmd(RGGEN_READ, 8'h10, '0, '0);
        @(negedge clk);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("first_issue_not_cycle1", 64'(bus_if.valid), 64'(0));
        @(negedge clk);
        check("first_issue_cycle2", 64'(bus_if.valid), 64'(1));
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("read_rsp_status", 64'(rsp_status), 64'(RGGEN_OKAY));
        check("read_rsp_data", 64'(rsp_read_data), 64'(32'hCAFE_F00D));
        wait_idle();

        // Zero-wait write.
        tgt_force_wait = 0;
        tgt_force_data = 1'b0;
        tgt_force_status = -1;
        send_cmd(RGGEN_WRITE, 8'h04, 32'h1234_5678, 4'hF);
        wait_idle();

        // Error response followed by another command.
        tgt_force_status = int'(RGGEN_SLAVE_ERROR);
        tgt_force_data = 1'b1;
        tgt_data_value = '0;
        tgt_force_wait = 1;
        send_cmd(RGGEN_READ, 8'h20, '0, '0);
        send_cmd(RGGEN_POSTED_WRITE, 8'h24, 32'hA5A5_0001, 4'h3);
        wait_idle();
        tgt_force_status = -1;
        tgt_force_data = 1'b0;

        // Fill the queue while a response is held, then release back-pressure.
        rsp_ready_dir = 1'b0;
        send_cmd(RGGEN_READ, 8'h40, '0, '0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            send_cmd(RGGEN_WRITE, AW'(4 * k), BW'($urandom), 4'hF);
            check("cmd_ready_while_filling", 64'(cmd_ready), 64'(k < DEPTH - 1));
        end
        drive_cmd(RGGEN_WRITE, 8'h80, 32'hDEAD_BEEF, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("fifth_cmd_blocked", 64'(cmd_ready), 64'(0));
            check("rsp_held_under_backpressure", 64'(rsp_valid), 64'(1));
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rsp_ready_dir = 1'b1;
        wait_idle();
        tgt_force_wait = -1;

        // Randomised traffic with random response back-pressure.
        rsp_random = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send_cmd(rand_access(), AW'($urandom) & ~AW'(3), BW'($urandom), 4'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();
        rsp_random = 1'b0;
        rsp_ready_dir = 1'b1;

        // Reset while a request is outstanding and two commands are queued.
        tgt_force_wait = 20;
        for (int k = 0; k < 3; k++) send_cmd(RGGEN_READ, AW'(8'h60 + 4 * k), '0, '0);
        @(negedge clk);
        check("pre_reset_in_request", 64'(bus_if.valid), 64'(1));
        check("pre_reset_busy", 64'(busy), 64'(1));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_cmd_q.delete();
        exp_rsp_q.delete();
        bus_if.ready = 1'b0;
        #1;
        check("async_reset_valid", 64'(bus_if.valid), 64'(0));
        check("async_reset_busy", 64'(busy), 64'(0));
        check("async_reset_cmd_ready", 64'(cmd_ready), 64'(1));
        check("async_reset_rsp_valid", 64'(rsp_valid), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tgt_force_wait = -1;
        quiet = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus_if.valid || rsp_valid || busy) quiet++;
        end
        check("post_reset_quiet", 64'(quiet), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/rggen_bus_initiator.md
RGGEN_BUS_INITIATOR -- requirements
Module: rggen_bus_initiator

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, the bus address width.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, the data width; strobe width is BUS_WIDTH/8.
REQ-003 SHALL have parameter COMMAND_DEPTH, default 4, the command queue entries (>=2).
REQ-004 SHALL have reset i_rst_n, asynchronous, active-low; clock i_clk.
REQ-005 SHALL have the following ports, clock and reset first:
- i_clk  in  1  clock.
- i_rst_n  in  1  async active-low reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  queue can accept a command.
- i_cmd_access  in  rggen_access  read/write/posted-write.
- i_cmd_address  in  ADDRESS_WIDTH  byte address.
- i_cmd_write_data  in  BUS_WIDTH  write data.
- i_cmd_strobe  in  BUS_WIDTH/8  byte strobes.
- o_rsp_valid  out  1  response held.
- i_rsp_ready  in  1  response consumed.
- o_rsp_status  out  rggen_status  captured status.
- o_rsp_read_data  out  BUS_WIDTH  captured read data.
- o_busy  out  1  queue non-empty or transaction in flight.
- bus_if  rggen_bus_if.master  drives valid/access/address/write_data/strobe; samples ready/status/read_data.

Function
REQ-006 SHALL accept a command on a clock edge where i_cmd_valid && o_cmd_ready; o_cmd_ready = queue not full, regardless of same-cycle pop.
REQ-007 SHALL issue commands strictly in acceptance order, one outstanding bus transaction at a time.
REQ-008 SHALL implement states IDLE, REQUEST, RESPONSE.
REQ-009 IDLE: when queue non-empty, pop head into request register on the edge, go to REQUEST.
REQ-010 REQUEST: bus_if.valid = 1 with fields from the request register; fields SHALL stay stable until bus_if.ready is sampled high.
REQ-011 REQUEST: on edge with bus_if.ready = 1, capture bus_if.status and bus_if.read_data into response registers, go to RESPONSE; bus_if.valid = 0 the next cycle.
REQ-012 bus_if.ready high in the first REQUEST cycle SHALL complete the transaction after exactly one valid cycle.
REQ-013 RESPONSE: o_rsp_valid = 1, status/read_data held stable until i_rsp_ready sampled high.
REQ-014 RESPONSE with i_rsp_ready: if queue non-empty, pop and go directly to REQUEST; else go to IDLE.
REQ-015 First bus_if.valid SHALL occur in the 2nd cycle after command acceptance when IDLE with an empty queue.
REQ-016 Posted writes SHALL still wait for bus_if.ready and produce a response.
REQ-017 o_busy = (state != IDLE) || queue non-empty.
REQ-018 Queue pointers SHALL wrap modulo COMMAND_DEPTH; an occupancy counter of width $clog2(COMMAND_DEPTH+1) distinguishes full from empty.

Reset
REQ-019 On i_rst_n low, immediately: state IDLE, queue empty, bus_if.valid 0, o_rsp_valid 0, o_busy 0, o_cmd_ready 1, response registers 0, request register 0.
REQ-020 Reset mid-transaction SHALL discard the in-flight command and all queued commands; no response is produced for them.

Structure
REQ-021 SHALL use rggen_access and rggen_status from rggen_rtl_pkg; no new package types.
REQ-022 State encoding SHALL be a local enum inside the module.
REQ-023 Command queue SHALL be one sub-module rggen_initiator_fifo (WIDTH, DEPTH parameters, push/pop/full/empty, async reset).

Verification
REQ-024 Single read: cmd READ addr 0x10; target returns ready after 3 wait cycles with OKAY, 0xCAFE_F00D -> valid high 4 cycles, fields stable, o_rsp_status OKAY, o_rsp_read_data 0xCAFE_F00D.
REQ-025 Zero-wait write: cmd WRITE addr 0x04 data 0x1234_5678 strobe 0xF, ready same cycle as valid -> exactly one valid cycle; response valid the next cycle.
REQ-026 Fill queue: push 4 commands with rsp_ready held 0 -> o_cmd_ready 0 after 4th accept; pushing a 5th has no effect; order of addresses 0x00,0x04,0x08,0x0C preserved on bus.
REQ-027 Back-pressure: i_rsp_ready low 5 cycles -> response fields stable, no new bus_if.valid; on i_rsp_ready high, next request valid in following cycle.
REQ-028 Error: target returns SLAVE_ERROR with read data 0 -> o_rsp_status SLAVE_ERROR, subsequent command still issued.
REQ-029 Reset in REQUEST with 2 queued commands -> bus_if.valid drops asynchronously, o_busy 0, no responses after release.
